mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter LATENCY, 4, clock edges from request acceptance to mem_ready; legal range 1..15.
REQ-002 Parameter IDX_W, 8, line-index width; storage depth is 2^IDX_W lines of 128 bits.
REQ-003 Ports: clk  in  1  single clock; all sequential logic SHALL use its rising edge.
REQ-004 Ports: proc_reset_n  in  1  reset; SHALL be asynchronous and active-low.
REQ-005 Ports: mem_read  in  1  line-read request, held by the initiator until mem_ready.
REQ-006 Ports: mem_write  in  1  line-write request, held by the initiator until mem_ready.
REQ-007 Ports: mem_addr  in  28  word address; line index SHALL be mem_addr[IDX_W+1:2].
REQ-008 Ports: mem_wdata  in  128  write line; word 0 in bits [31:0].
REQ-009 Ports: mem_rdata  out  128  read line, registered.
REQ-010 Ports: mem_ready  out  1  one-cycle completion pulse, registered.

Function
REQ-011 FSM states SHALL be IDLE, WAIT, RESP.
- IDLE -> WAIT on mem_read|mem_write.
- WAIT -> RESP when the countdown expires.
- RESP -> IDLE unconditionally.
REQ-012 On the accepting edge in IDLE:
- latch line index, operation and mem_wdata;
- load the countdown with LATENCY-1.
REQ-013 The countdown SHALL decrement once per edge in WAIT; WAIT -> RESP when it reaches 0.
REQ-014 With LATENCY=1, IDLE SHALL go directly to RESP and WAIT SHALL be skipped.
REQ-015 mem_ready SHALL be 1 only in RESP, exactly one cycle, LATENCY edges after the accepting edge.
REQ-016 Read: mem_rdata SHALL equal the stored line at the latched index throughout the RESP cycle.
REQ-017 Write: the latched line SHALL be committed to storage on the edge entering RESP; mem_rdata SHALL be 0 during a write RESP.
REQ-018 mem_rdata SHALL be 0 whenever mem_ready is 0.
REQ-019 Request inputs SHALL be ignored in WAIT and RESP; only the values latched at acceptance are used.
- An initiator may switch from write to read during the RESP cycle.
- That new request SHALL be accepted in the following IDLE cycle.
REQ-020 Back-to-back requests SHALL be spaced LATENCY+1 edges apart (one IDLE turnaround cycle).
REQ-021 If mem_read and mem_write are both 1 at acceptance, the request SHALL be treated as a write.
REQ-022 Address bits above IDX_W+1 and bits [1:0] SHALL be ignored, so indices alias modulo 2^IDX_W.
REQ-023 A read issued after a write to the same index SHALL return the written line.

Reset
REQ-024 When proc_reset_n=0, immediately and independent of clk:
- state=IDLE, countdown=0;
- mem_ready=0, mem_rdata=0;
- latched index/operation/data cleared.
REQ-025 Reset asserted mid-transaction SHALL abort it: no mem_ready pulse, and a write not yet committed is discarded.
REQ-026 After reset release, the first request SHALL be accepted on the first rising edge with proc_reset_n=1.

Configuration
REQ-027 Macro MEM_RESP_ZERO_INIT_EN:
- defined: every storage line SHALL be cleared to 0 on reset;
- undefined: storage SHALL be unaffected by reset and hold prior contents.

Verification
REQ-028 LATENCY=4: write 0x...DEADBEEF_0000000F to mem_addr 0x0000010, then read the same address -> read mem_ready 4 edges after acceptance, mem_rdata equals the written line, 5-edge request spacing.
REQ-029 Hold mem_write to index 3 until ready; during the ready cycle switch to mem_read of index 7 -> write committed, read accepted next cycle and returns line 7.
REQ-030 IDX_W=8: write to mem_addr 0x0000004, read mem_addr 0x0000404 -> same line returned (alias).
REQ-031 Assert proc_reset_n=0 two edges into a write to index 5 -> mem_ready never pulses; line 5 unchanged; with MEM_RESP_ZERO_INIT_EN, line 5 reads 0.
REQ-032 LATENCY=1: read request -> mem_ready on the edge after acceptance, no WAIT state visited.
REQ-033 mem_read=mem_write=1 with data 0xA5 pattern -> behaves as write; subsequent read returns the 0xA5 pattern.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency 128-bit line memory that answers one request at a time.
//
// Ports:
//   clk           rising-edge clock for all sequential logic
//   proc_reset_n  asynchronous active-low reset
//   mem_read      line-read request, held by the initiator until mem_ready
//   mem_write     line-write request, held by the initiator until mem_ready (wins over mem_read)
//   mem_addr      28-bit word address; line index is mem_addr[IDX_W+1:2]
//   mem_wdata     128-bit write line, word 0 in bits [31:0]
//   mem_rdata     registered read line, 0 except during a read response
//   mem_ready     registered one-cycle completion pulse
//
// Parameters:
//   LATENCY  edges from acceptance to the edge that samples mem_ready (1..15)
//   IDX_W    line-index width; storage holds 2^IDX_W lines
//
// Build option:
//   MEM_RESP_ZERO_INIT_EN  when defined, reset clears every storage line;
//                          otherwise storage keeps its contents through reset.
//
// State table:
//   IDLE | waiting for a request; a request is latched on the next edge
//   WAIT | countdown running; request inputs are ignored
//   RESP | mem_ready high for this single cycle; always returns to IDLE

module mem_responder #(
    parameter int LATENCY = 4,
    parameter int IDX_W   = 8
) (
    input  logic         clk,
    input  logic         proc_reset_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [27:0]  mem_addr,
    input  logic [127:0] mem_wdata,
    output logic [127:0] mem_rdata,
    output logic         mem_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int          DEPTH    = 1 << IDX_W;
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               wr_q, wr_d;
    logic [127:0]       data_q, data_d;
    logic               enter_resp;
    logic               mem_we;

    logic [127:0]       store [DEPTH];

    // Address bits outside the line index are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr[27:IDX_W+2], mem_addr[1:0]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wr_d       = wr_q;
        data_d     = data_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    idx_d  = mem_addr[IDX_W+1:2];
                    wr_d   = mem_write;
                    data_d = mem_wdata;
                    cnt_d  = CNT_LOAD;
                    if (LATENCY == 1) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                // RESP is entered on the edge where the count reaches 0, so the
                // registered pulse is sampled LATENCY edges after acceptance.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d      = 4'd0;
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The *_d values are used so a LATENCY=1 request commits/reads on its
    // accepting edge, before the latches have captured it.
    assign mem_we = enter_resp && wr_d && proc_reset_n;

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            idx_q     <= '0;
            wr_q      <= 1'b0;
            data_q    <= '0;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            wr_q      <= wr_d;
            data_q    <= data_d;
            mem_ready <= enter_resp;
            mem_rdata <= (enter_resp && !wr_d) ? store[idx_d] : '0;
        end
    end

`ifdef MEM_RESP_ZERO_INIT_EN
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                store[i] <= '0;
            end
        end else if (mem_we) begin
            store[idx_d] <= data_d;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (mem_we) begin
            store[idx_d] <= data_d;
        end
    end
`endif

endmodule
